// File: rtl/calib_sequencer.sv
// ---------------------------------------------------------------------------
// calib_sequencer
//
// Sequences a corner-zone calibration run. Once started, it waits for the
// first frame boundary. It then samples the four zone FSMs once per frame
// until they have all been locked for STABLE_FRAMES consecutive frames. At
// that point it pulses the latch command to the calibration block for two
// cycles and checks that the latched corners span a large enough area.
//
// A failed span check, or an attempt that runs TIMEOUT_FRAMES frames
// without converging, is retried up to MAX_RETRY times before the run
// ends in FAIL.
//
// Ports
//   clk                 pixel clock
//   reset_n             asynchronous active-low reset
//   start               single-cycle run request (ignored while busy)
//   hcount, vcount      raster position; (0,0) marks a frame boundary
//   state1..state4      zone FSM states, compared against LOCK_CODE
//   xo, xf, yo, yf      corner centres reported by the calibration block
//   calibrated          latch command, high for the two LATCH cycles
//   busy                run in progress (WAIT_FRAME .. CHECK)
//   cal_ok, cal_fail    outcome of the last run (levels)
//   retry_cnt           retries used in the current or last run
//   phase               current FSM state encoding
//
// state       | meaning
// ------------+-----------------------------------------------------------
// IDLE     0  | out of reset, waiting for start
// WAIT_FRAME 1| waiting for the next frame boundary (not sampled)
// SAMPLE   2  | counting frames and consecutive all-locked frames
// LATCH    3  | calibrated held high, two cycles
// CHECK    4  | one-cycle corner span check
// DONE     5  | run succeeded, cal_ok high until next start
// FAIL     6  | retries exhausted, cal_fail high until next start
// ---------------------------------------------------------------------------
module calib_sequencer #(
    parameter logic [2:0]  LOCK_CODE      = 3'd3,
    parameter int unsigned STABLE_FRAMES  = 8,
    parameter int unsigned TIMEOUT_FRAMES = 120,
    parameter int unsigned MIN_SPAN_X     = 100,
    parameter int unsigned MIN_SPAN_Y     = 75,
    parameter int unsigned MAX_RETRY      = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [10:0] hcount,
    input  logic [10:0] vcount,
    input  logic [2:0]  state1,
    input  logic [2:0]  state2,
    input  logic [2:0]  state3,
    input  logic [2:0]  state4,
    input  logic [10:0] xo,
    input  logic [10:0] xf,
    input  logic [10:0] yo,
    input  logic [10:0] yf,
    output logic        calibrated,
    output logic        busy,
    output logic        cal_ok,
    output logic        cal_fail,
    output logic [1:0]  retry_cnt,
    output logic [2:0]  phase
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_FRAME = 3'd1,
        ST_SAMPLE     = 3'd2,
        ST_LATCH      = 3'd3,
        ST_CHECK      = 3'd4,
        ST_DONE       = 3'd5,
        ST_FAIL       = 3'd6
    } state_e;

    localparam logic [3:0]  STABLE_C  = 4'(STABLE_FRAMES);
    localparam logic [7:0]  TIMEOUT_C = 8'(TIMEOUT_FRAMES);
    localparam logic [1:0]  MAX_RTY_C = 2'(MAX_RETRY);
    localparam logic [11:0] SPAN_X_C  = 12'(MIN_SPAN_X);
    localparam logic [11:0] SPAN_Y_C  = 12'(MIN_SPAN_Y);

    state_e      state_q, state_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic [3:0]  stable_cnt_q, stable_cnt_d;
    logic [1:0]  latch_cnt_q, latch_cnt_d;
    logic [1:0]  retry_cnt_q, retry_cnt_d;
    logic        calibrated_q, calibrated_d;
    logic        busy_q, busy_d;
    logic        cal_ok_q, cal_ok_d;
    logic        cal_fail_q, cal_fail_d;
    logic        origin_q, origin_d;

    logic        origin;
    logic        frame_tick;
    logic        all_locked;
    logic        span_ok;
    logic        take_retry;
    logic [7:0]  frame_inc;
    logic [3:0]  stable_inc;

    // The raster may sit on (0,0) for several clocks; only the first counts.
    assign origin     = (hcount == 11'd0) && (vcount == 11'd0);
    assign origin_d   = origin;
    assign frame_tick = origin && !origin_q;

    assign all_locked = (state1 == LOCK_CODE) && (state2 == LOCK_CODE) &&
                        (state3 == LOCK_CODE) && (state4 == LOCK_CODE);

    // Zero-extended to 12 bits so a corner near the top of the range
    // cannot wrap the sum and fake a pass.
    assign span_ok = ({1'b0, xf} >= ({1'b0, xo} + SPAN_X_C)) &&
                     ({1'b0, yf} >= ({1'b0, yo} + SPAN_Y_C));

    // Counters saturate rather than wrap.
    assign frame_inc  = (frame_cnt_q == 8'hFF) ? frame_cnt_q : frame_cnt_q + 8'd1;
    assign stable_inc = (stable_cnt_q == 4'hF) ? stable_cnt_q : stable_cnt_q + 4'd1;

    always_comb begin
        state_d      = state_q;
        frame_cnt_d  = frame_cnt_q;
        stable_cnt_d = stable_cnt_q;
        latch_cnt_d  = latch_cnt_q;
        retry_cnt_d  = retry_cnt_q;
        cal_ok_d     = cal_ok_q;
        cal_fail_d   = cal_fail_q;
        take_retry   = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE, ST_FAIL: begin
                if (start) begin
                    frame_cnt_d  = 8'd0;
                    stable_cnt_d = 4'd0;
                    latch_cnt_d  = 2'd0;
                    retry_cnt_d  = 2'd0;
                    cal_ok_d     = 1'b0;
                    cal_fail_d   = 1'b0;
                    state_d      = ST_WAIT_FRAME;
                end
            end
            ST_WAIT_FRAME: begin
                if (frame_tick) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (frame_tick) begin
                    frame_cnt_d  = frame_inc;
                    stable_cnt_d = all_locked ? stable_inc : 4'd0;
                    // Convergence takes priority over timeout on the same frame.
                    if (all_locked && (stable_inc == STABLE_C)) begin
                        latch_cnt_d = 2'd0;
                        state_d     = ST_LATCH;
                    end else if (frame_inc == TIMEOUT_C) begin
                        take_retry = 1'b1;
                    end
                end
            end
            ST_LATCH: begin
                latch_cnt_d = latch_cnt_q + 2'd1;
                if (latch_cnt_q == 2'd1) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (span_ok) begin
                    cal_ok_d = 1'b1;
                    state_d  = ST_DONE;
                end else begin
                    take_retry = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Shared by the timeout and span-fail paths.
        if (take_retry) begin
            if (retry_cnt_q < MAX_RTY_C) begin
                retry_cnt_d  = retry_cnt_q + 2'd1;
                frame_cnt_d  = 8'd0;
                stable_cnt_d = 4'd0;
                state_d      = ST_WAIT_FRAME;
            end else begin
                cal_fail_d = 1'b1;
                state_d    = ST_FAIL;
            end
        end

        // Outputs follow the next state so they line up with phase.
        calibrated_d = (state_d == ST_LATCH);
        busy_d       = (state_d == ST_WAIT_FRAME) || (state_d == ST_SAMPLE) ||
                       (state_d == ST_LATCH)      || (state_d == ST_CHECK);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            frame_cnt_q  <= 8'd0;
            stable_cnt_q <= 4'd0;
            latch_cnt_q  <= 2'd0;
            retry_cnt_q  <= 2'd0;
            calibrated_q <= 1'b0;
            busy_q       <= 1'b0;
            cal_ok_q     <= 1'b0;
            cal_fail_q   <= 1'b0;
            origin_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_cnt_q  <= frame_cnt_d;
            stable_cnt_q <= stable_cnt_d;
            latch_cnt_q  <= latch_cnt_d;
            retry_cnt_q  <= retry_cnt_d;
            calibrated_q <= calibrated_d;
            busy_q       <= busy_d;
            cal_ok_q     <= cal_ok_d;
            cal_fail_q   <= cal_fail_d;
            origin_q     <= origin_d;
        end
    end

    assign calibrated = calibrated_q;
    assign busy       = busy_q;
    assign cal_ok     = cal_ok_q;
    assign cal_fail   = cal_fail_q;
    assign retry_cnt  = retry_cnt_q;
    assign phase      = state_q;

endmodule

// File: tb/tb_calib_sequencer.sv
// ---------------------------------------------------------------------------
// tb_calib_sequencer
//
// Directed bench for calib_sequencer. Frame boundaries are compressed to
// one raster-origin clock every second cycle. Outputs are sampled 1 ns
// after the rising edge and compared against hand-derived values.
// ---------------------------------------------------------------------------
module tb_calib_sequencer;

    localparam logic [2:0] LOCK = 3'd3;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [10:0] hcount, vcount;
    logic [2:0]  state1, state2, state3, state4;
    logic [10:0] xo, xf, yo, yf;
    logic        calibrated, busy, cal_ok, cal_fail;
    logic [1:0]  retry_cnt;
    logic [2:0]  phase;

    int n_pass  = 0;
    int n_total = 0;
    int latch_pulses = 0;
    logic cal_prev = 1'b0;

    calib_sequencer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .hcount     (hcount),
        .vcount     (vcount),
        .state1     (state1),
        .state2     (state2),
        .state3     (state3),
        .state4     (state4),
        .xo         (xo),
        .xf         (xf),
        .yo         (yo),
        .yf         (yf),
        .calibrated (calibrated),
        .busy       (busy),
        .cal_ok     (cal_ok),
        .cal_fail   (cal_fail),
        .retry_cnt  (retry_cnt),
        .phase      (phase)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Rising edges of calibrated, and cal_ok/cal_fail exclusivity.
    always @(negedge clk) begin
        if (calibrated && !cal_prev) latch_pulses++;
        cal_prev = calibrated;
        if (reset_n) chk("ok_fail_exclusive", int'(cal_ok & cal_fail), 0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_zones(input bit locked);
        state1 = locked ? LOCK : 3'd1;
        state2 = locked ? LOCK : 3'd1;
        state3 = locked ? LOCK : 3'd1;
        state4 = locked ? LOCK : 3'd1;
    endtask

    // One off-origin cycle, then one origin cycle; returns just after the
    // edge on which the tick was consumed.
    task automatic tick(input bit locked);
        set_zones(locked);
        hcount = 11'd5;
        vcount = 11'd7;
        step();
        hcount = 11'd0;
        vcount = 11'd0;
        step();
        hcount = 11'd5;
        vcount = 11'd7;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        hcount  = 11'd5;
        vcount  = 11'd7;
        set_zones(1'b0);
        xo = 11'd100; xf = 11'd600;
        yo = 11'd100; yf = 11'd450;

        // Reset state
        step(); step();
        chk("rst_phase", int'(phase), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_cal", int'(calibrated), 0);
        chk("rst_ok", int'(cal_ok), 0);
        chk("rst_fail", int'(cal_fail), 0);
        chk("rst_retry", int'(retry_cnt), 0);
        reset_n = 1'b1;
        step(); step();
        chk("idle_no_start", int'(phase), 0);

        // Happy path
        pulse_start();
        chk("hp_wait", int'(phase), 1);
        chk("hp_busy", int'(busy), 1);
        tick(1'b1);
        chk("hp_sample", int'(phase), 2);
        for (int i = 2; i <= 8; i++) tick(1'b1);
        chk("hp_tick8_sample", int'(phase), 2);
        chk("hp_tick8_nocal", int'(calibrated), 0);
        tick(1'b1);
        chk("hp_latch1_phase", int'(phase), 3);
        chk("hp_latch1_cal", int'(calibrated), 1);
        step();
        chk("hp_latch2_phase", int'(phase), 3);
        chk("hp_latch2_cal", int'(calibrated), 1);
        step();
        chk("hp_check_phase", int'(phase), 4);
        chk("hp_check_cal", int'(calibrated), 0);
        chk("hp_check_busy", int'(busy), 1);
        // start coincides with the transition into DONE
        pulse_start();
        chk("hp_done_phase", int'(phase), 5);
        chk("hp_done_ok", int'(cal_ok), 1);
        chk("hp_done_busy", int'(busy), 0);
        chk("hp_done_retry", int'(retry_cnt), 0);
        step();
        chk("hp_done_stays", int'(phase), 5);

        // Glitch on sampled frame 5
        pulse_start();
        chk("gl_wait", int'(phase), 1);
        chk("gl_ok_cleared", int'(cal_ok), 0);
        tick(1'b1);
        for (int i = 1; i <= 12; i++) tick(i != 5);
        chk("gl_f12_sample", int'(phase), 2);
        tick(1'b1);
        chk("gl_f13_latch", int'(phase), 3);
        step(); step(); step();
        chk("gl_done", int'(phase), 5);
        chk("gl_ok", int'(cal_ok), 1);

        // Span failure on every attempt
        xf = 11'd150;
        latch_pulses = 0;
        pulse_start();
        for (int a = 0; a < 4; a++) begin
            tick(1'b1);
            for (int i = 1; i <= 8; i++) tick(1'b1);
            chk("sp_latch", int'(phase), 3);
            step(); step(); step();
            if (a < 3) begin
                chk("sp_retry_phase", int'(phase), 1);
                chk("sp_retry_cnt", int'(retry_cnt), a + 1);
            end
        end
        chk("sp_fail_phase", int'(phase), 6);
        chk("sp_fail_flag", int'(cal_fail), 1);
        chk("sp_fail_ok", int'(cal_ok), 0);
        chk("sp_fail_retry", int'(retry_cnt), 3);
        chk("sp_fail_busy", int'(busy), 0);
        chk("sp_latch_pulses", latch_pulses, 4);

        // Timeout: zones never lock
        xf = 11'd600;
        latch_pulses = 0;
        pulse_start();
        chk("to_fail_cleared", int'(cal_fail), 0);
        chk("to_retry_cleared", int'(retry_cnt), 0);
        for (int a = 0; a < 4; a++) begin
            tick(1'b0);
            for (int i = 1; i <= 119; i++) tick(1'b0);
            chk("to_f119_sample", int'(phase), 2);
            tick(1'b0);
            if (a < 3) begin
                chk("to_retry_phase", int'(phase), 1);
                chk("to_retry_cnt", int'(retry_cnt), a + 1);
            end
        end
        chk("to_fail_phase", int'(phase), 6);
        chk("to_fail_flag", int'(cal_fail), 1);
        chk("to_retry_final", int'(retry_cnt), 3);
        chk("to_no_latch", latch_pulses, 0);

        // Reset in the first LATCH cycle
        pulse_start();
        for (int i = 1; i <= 9; i++) tick(1'b1);
        chk("rl_latch", int'(phase), 3);
        chk("rl_cal_hi", int'(calibrated), 1);
        reset_n = 1'b0;
        #1;
        chk("rl_cal_lo", int'(calibrated), 0);
        chk("rl_phase", int'(phase), 0);
        chk("rl_busy", int'(busy), 0);
        start = 1'b1;
        step(); step();
        chk("rl_start_ignored", int'(phase), 0);
        start = 1'b0;
        reset_n = 1'b1;
        step(); step();
        chk("rl_idle_after", int'(phase), 0);
        chk("rl_retry", int'(retry_cnt), 0);

        // Held origin gives one tick; start during SAMPLE is ignored
        pulse_start();
        chk("rt_wait", int'(phase), 1);
        set_zones(1'b1);
        hcount = 11'd0;
        vcount = 11'd0;
        step(); step(); step();
        hcount = 11'd5;
        vcount = 11'd7;
        chk("rt_sample", int'(phase), 2);
        for (int i = 1; i <= 4; i++) tick(1'b1);
        pulse_start();
        chk("rt_busy_start_phase", int'(phase), 2);
        chk("rt_busy_start_busy", int'(busy), 1);
        for (int i = 5; i <= 7; i++) tick(1'b1);
        chk("rt_f7_sample", int'(phase), 2);
        tick(1'b1);
        chk("rt_f8_latch", int'(phase), 3);
        step(); step(); step();
        chk("rt_done", int'(phase), 5);
        chk("rt_ok", int'(cal_ok), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
